piso_serializer: RTL and testbench

- Parallel-in/serial-out transmitter built on a chain of clocked D storage elements.
- Accepts a WIDTH-bit word through a valid/ready load handshake, then shifts it out MSB-first, one bit per clk.
- Serves as the transmit end for the serial-to-parallel receive path and feeds single-wire links, LED and pin drivers in the design.

---
 rtl/piso_serializer.sv | 124 ++++++++++++
 tb/tb_piso_serializer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: valid/ready word load, MSB-first shift, one bit per clk.
// Optional PARITY_EN appends an even-parity bit after the data word.
module piso_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             serial_last
);

  localparam int unsigned CW = $clog2(WIDTH);

`ifdef PARITY_EN
  typedef enum logic [1:0] {StIdle, StShift, StPar} state_e;
`else
  typedef enum logic [1:0] {StIdle, StShift} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
`ifdef PARITY_EN
  logic             parity_q, parity_d;
`endif

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    last_d   = last_q;
`ifdef PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (load_valid) begin
          state_d  = StShift;
          shreg_d  = data_in;
          cnt_d    = CW'(WIDTH - 1);
          valid_d  = 1'b1;
          last_d   = 1'b0;
`ifdef PARITY_EN
          parity_d = ^data_in;
`endif
        end
      end
      StShift: begin
        if (cnt_q != '0) begin
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q - CW'(1);
`ifdef PARITY_EN
          last_d  = 1'b0;
`else
          last_d  = (cnt_q == CW'(1));
`endif
        end else begin
`ifdef PARITY_EN
          // Parity bit rides in the MSB so serial_out stays a direct flop output.
          state_d = StPar;
          shreg_d = {parity_q, {(WIDTH-1){1'b0}}};
          valid_d = 1'b1;
          last_d  = 1'b1;
`else
          state_d = StIdle;
          shreg_d = '0;
          valid_d = 1'b0;
          last_d  = 1'b0;
`endif
        end
      end
`ifdef PARITY_EN
      StPar: begin
        state_d = StIdle;
        shreg_d = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
`endif
      default: begin
        state_d = StIdle;
        shreg_d = '0;
        cnt_d   = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      shreg_q  <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
`ifdef PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
`ifdef PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign load_ready   = (state_q == StIdle);
  assign serial_out   = shreg_q[WIDTH-1];
  assign serial_valid = valid_q;
  assign serial_last  = last_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: frame-queue model checked every cycle,
// plus literal per-frame expectations. Honours PARITY_EN when defined.
module tb_piso_serializer;

  localparam int unsigned W = 8;
`ifdef PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] data_in = '0;
  logic         load_valid = 1'b0;
  logic         load_ready, serial_out, serial_valid, serial_last;

  int n_checks = 0;
  int n_fail   = 0;

  piso_serializer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .serial_out  (serial_out),
    .serial_valid(serial_valid),
    .serial_last (serial_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: queue of pending frame bits; an empty queue means idle and ready.
  typedef struct packed {
    logic b;
    logic l;
  } item_t;
  item_t exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
    end else if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end else if (load_valid) begin
      item_t it;
      for (int i = W - 1; i >= 0; i--) begin
        it.b = data_in[i];
        it.l = (i == 0) && (FL == W);
        exp_q.push_back(it);
      end
`ifdef PARITY_EN
      it.b = ^data_in;
      it.l = 1'b1;
      exp_q.push_back(it);
`endif
    end
  end

  logic bits_q[$];
  logic lasts_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() != 0) begin
        chk("cyc_valid", serial_valid, 1);
        chk("cyc_out", serial_out, exp_q[0].b);
        chk("cyc_last", serial_last, exp_q[0].l);
        chk("cyc_ready", load_ready, 0);
      end else begin
        chk("idle_valid", serial_valid, 0);
        chk("idle_out", serial_out, 0);
        chk("idle_last", serial_last, 0);
        chk("idle_ready", load_ready, 1);
      end
      if (serial_valid) begin
        bits_q.push_back(serial_out);
        lasts_q.push_back(serial_last);
      end
    end
  end

  task automatic send(input logic [W-1:0] w, input bit drop);
    data_in    = w;
    load_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (load_ready) begin
        @(posedge clk);
        #1;
        if (drop) load_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    chk("accept_timeout", 0, 1);
    load_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64; i++) begin
      if (load_ready && !serial_valid) return;
      @(posedge clk);
      #1;
    end
    chk("idle_timeout", 0, 1);
  endtask

  task automatic check_frame(input string name, input int start, input logic [15:0] exp);
    logic [15:0] word;
    int nlast;
    word  = '0;
    nlast = 0;
    if (bits_q.size() < start + FL) begin
      chk({name, "_len"}, bits_q.size() - start, FL);
      return;
    end
    for (int i = 0; i < FL; i++) begin
      word = {word[14:0], bits_q[start+i]};
      if (lasts_q[start+i]) nlast++;
    end
    chk(name, word, exp);
    chk({name, "_lastpos"}, lasts_q[start+FL-1], 1);
    chk({name, "_nlast"}, nlast, 1);
  endtask

`ifdef PARITY_EN
  localparam logic [15:0] E_A5 = 16'h014A, E_FF = 16'h01FE, E_81 = 16'h0102;
  localparam logic [15:0] E_3C = 16'h0078, E_07 = 16'h000F, E_00 = 16'h0000;
`else
  localparam logic [15:0] E_A5 = 16'h00A5, E_FF = 16'h00FF, E_81 = 16'h0081;
  localparam logic [15:0] E_3C = 16'h003C, E_07 = 16'h0007, E_00 = 16'h0000;
`endif

  initial begin
    int s;
    // load_valid high during reset must be ignored.
    load_valid = 1'b1;
    data_in    = 8'hFF;
    #1;
    chk("rst_valid", serial_valid, 0);
    chk("rst_out", serial_out, 0);
    chk("rst_last", serial_last, 0);
    chk("rst_ready", load_ready, 1);
    repeat (2) @(negedge clk);
    load_valid = 1'b0;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Async reset pulse while idle, mid clk-low.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rstidle_ready", load_ready, 1);
    chk("rstidle_valid", serial_valid, 0);
    @(negedge clk);
    #1 rst = 1'b0;

    // Basic A5 frame.
    s = bits_q.size();
    send(8'hA5, 1'b1);
    wait_idle();
    check_frame("a5", s, E_A5);

    // load_valid with FF while busy: ignored until ready rises.
    s = bits_q.size();
    send(8'hA5, 1'b1);
    @(posedge clk);
    #1;
    data_in    = 8'hFF;
    load_valid = 1'b1;
    send(8'hFF, 1'b1);
    wait_idle();
    check_frame("busy_a5", s, E_A5);
    check_frame("busy_ff", s + FL, E_FF);

    // Reset after the 3rd bit of 3C aborts the frame immediately.
    s = bits_q.size();
    send(8'h3C, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_valid", serial_valid, 0);
    chk("abort_last", serial_last, 0);
    chk("abort_out", serial_out, 0);
    chk("abort_ready", load_ready, 1);
    chk("abort_nbits", bits_q.size() - s, 3);
    for (int i = s; i < bits_q.size(); i++) chk("abort_nolast", lasts_q[i], 0);
    @(negedge clk);
    #1 rst = 1'b0;
    s = bits_q.size();
    send(8'h81, 1'b1);
    wait_idle();
    check_frame("post_rst_81", s, E_81);

    // Held load_valid: 81 then 3C with one idle cycle between (cycle model enforces the gap).
    s = bits_q.size();
    send(8'h81, 1'b0);
    send(8'h3C, 1'b1);
    wait_idle();
    check_frame("b2b_81", s, E_81);
    check_frame("b2b_3c", s + FL, E_3C);

    // Parity-sensitive words.
    s = bits_q.size();
    send(8'h07, 1'b1);
    wait_idle();
    check_frame("w07", s, E_07);
    s = bits_q.size();
    send(8'h00, 1'b1);
    wait_idle();
    check_frame("w00", s, E_00);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1);
  end

endmodule
